// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= IDLE_LEVEL;
            q    <= IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, single-byte holding register with
// valid/read handshake, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_line,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned          CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]           BIDX_LAST = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_param
        $error("uart_rx: CLKS_PER_BIT must be >= 4 and even");
    end

    uart_state_e          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2:0]           bidx, bidx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 accept, ferr;
    logic                 rx_s;

    uart_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_line),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        accept  = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_s == START_BIT) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (rx_s == START_BIT) begin
                        state_n = DATA;
                        bidx_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bidx == BIDX_LAST) state_n = STOP;
                    else                   bidx_n  = bidx + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s == STOP_BIT) begin
                        accept  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s == IDLE_LEVEL) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            bidx        <= '0;
            shreg       <= '1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            bidx        <= bidx_n;
            shreg       <= shreg_n;
            frame_error <= ferr;
            overrun     <= 1'b0;
            busy        <= (state_n != IDLE);
            if (accept) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_read;
            end else if (rx_read && rx_valid) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    typedef struct {
        logic [7:0] d;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx_line;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   exp_fe = 0;
    int   exp_ov = 0;
    bit   busy_seen = 0;
    logic m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    exp_t sbq[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_line     (rx_line),
        .rx_read     (rx_read),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every accepted byte is popped from the scoreboard.
    initial begin
        logic       pv;
        logic [7:0] pd;
        exp_t       e;
        pv = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv = 1'b0;
                pd = 8'h00;
            end else begin
                if (overrun || (rx_valid && (!pv || rx_data != pd))) begin
                    check("sb_pending", 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check("rx_data", 32'(rx_data), 32'(e.d));
                        check("overrun", 32'(overrun), 32'(e.ov));
                    end
                    if (rx_valid && !pv) rise_cyc = cyc;
                end
                if (frame_error) fe_cnt++;
                if (overrun) ov_cnt++;
                if (frame_error || overrun)
                    check("fe_ov_excl", 32'(frame_error & overrun), 32'd0);
                if (busy) busy_seen = 1'b1;
                pv = rx_valid;
                pd = rx_data;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit rd_at_accept);
        exp_t e;
        if (stop) begin
            e.d  = b;
            e.ov = m_valid && !rd_at_accept;
            if (e.ov) exp_ov++;
            sbq.push_back(e);
            m_valid = 1'b1;
            m_data  = b;
        end else begin
            exp_fe++;
        end
        start_cyc = cyc;
        for (int i = 0; i < 10 * CPB; i++) begin
            int   k;
            logic bitv;
            k = i / CPB;
            if (k == 0)      bitv = 1'b0;
            else if (k == 9) bitv = stop;
            else             bitv = b[k-1];
            rx_line = bitv;
            // Accept registers on the edge 155 clocks after the start drive.
            rx_read = rd_at_accept && (i == 154);
            tick(1);
        end
        rx_read = 1'b0;
    endtask

    task automatic host_read();
        rx_read = 1'b1;
        tick(1);
        rx_read = 1'b0;
        m_valid = 1'b0;
        tick(1);
        check("valid_after_read", 32'(rx_valid), 32'd0);
        check("data_after_read", 32'(rx_data), 32'(m_data));
    endtask

    task automatic wait_sb();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 400) begin
            tick(1);
            t++;
        end
        check("sb_drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, "_data"}, 32'(rx_data), 32'(m_data));
        check({tag, "_fe_cnt"}, 32'(fe_cnt), 32'(exp_fe));
        check({tag, "_ov_cnt"}, 32'(ov_cnt), 32'(exp_ov));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(rx_data), 32'd0);
        check({tag, "_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_fe"}, 32'(frame_error), 32'd0);
        check({tag, "_ov"}, 32'(overrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int lat_exp;
        reset   = 1'b0;
        rx_line = 1'b1;
        rx_read = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b1;
        tick(5);

        // Single frame, latency from the start edge.
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_sb();
        tick(4);
        lat = rise_cyc - start_cyc;
        lat_exp = (lat < 154) ? 154 : ((lat > 156) ? 156 : lat);
        check("latency", 32'(lat), 32'(lat_exp));
        check_state("a5");
        host_read();
        host_read();

        // Short glitch must not start a frame.
        busy_seen = 1'b0;
        rx_line = 1'b0;
        tick(4);
        rx_line = 1'b1;
        tick(20);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy", 32'(busy), 32'd0);
        check_state("glitch");

        // Framing error, then a stuck-low line held in WAIT_IDLE.
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_line = 1'b0;
        tick(40);
        check("ferr_busy_held", 32'(busy), 32'd1);
        check_state("ferr");
        rx_line = 1'b1;
        tick(6);
        check("ferr_busy_clear", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_sb();
        tick(4);
        check_state("after_ferr");
        host_read();

        // Back-to-back frames without reading: overrun on the second.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_sb();
        tick(4);
        check_state("overrun");
        host_read();

        // Read coinciding with the accept of the next byte: no overrun.
        send_frame(8'h66, 1'b1, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1);
        wait_sb();
        tick(4);
        check_state("read_at_accept");
        host_read();

        // Reset in the middle of a frame.
        rx_line = 1'b0;
        tick(CPB);
        rx_line = 1'b1;
        tick(4 * CPB);
        reset = 1'b0;
        #2;
        check_reset_outputs("midreset");
        m_valid = 1'b0;
        m_data  = 8'h00;
        tick(3);
        reset = 1'b1;
        tick(5);
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_sb();
        tick(4);
        check_state("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: idle-high line, one start bit (0), 8 data bits LSB first, one stop bit (1).
- Sits downstream of the transmit path: it consumes a serial line such as uart_tx's tx_data and presents whole bytes to the host logic.
- Oversamples the line at CLKS_PER_BIT clocks per bit and samples each bit at mid-bit.
- Holds one received byte in a holding register with a valid/read handshake, and flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must be >= 4 and even.
- DATA_BITS, 8, data bits per frame. Fixed at 8 in this revision.

Ports:
- clk  input  1  system clock.
- reset  input  1  one clock; reset is asynchronous and active-low.
- rx_line  input  1  asynchronous serial input; idle high.
- rx_read  input  1  one-cycle pulse from the host; consumes the held byte.
- rx_data  output  8  last accepted byte.
- rx_valid  output  1  high while rx_data holds an unread byte.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled 0.
- overrun  output  1  one-cycle pulse when a byte is accepted while rx_valid=1 and no rx_read.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE; rx_data=0x00, rx_valid=0, frame_error=0, overrun=0, busy=0. Synchronizer flops and the shift register reset to 1 (idle line). Reset mid-frame discards the partial byte.
- Synchronizer: rx_line passes through 2 flops (rx_s) before any use. This adds 2 cycles of latency.
- Bit counter: cnt, width clog2(CLKS_PER_BIT). Data-bit index: bidx, 3 bits.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START: cnt increments each clock. At cnt==CLKS_PER_BIT/2-1:
  - rx_s==0 -> DATA, cnt=0, bidx=0.
  - rx_s==1 (glitch) -> IDLE. No flags raised.
- DATA: at cnt==CLKS_PER_BIT-1 (mid-bit):
  - Sample rx_s into shift register MSB, shifting right. Clear cnt.
  - bidx==7 -> STOP; otherwise bidx+1.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
  - 1 -> accept: rx_data<=shift register, rx_valid<=1 on the next edge, FSM -> IDLE (resynchronises at mid-stop bit).
  - 0 -> frame_error pulse for 1 cycle, byte discarded, rx_data/rx_valid unchanged, FSM -> WAIT_IDLE.
- WAIT_IDLE: stays until rx_s==1, then IDLE. Breaks and stuck-low lines are absorbed here.
- Handshake:
  - rx_read while rx_valid=1 clears rx_valid on the next edge.
  - rx_read while rx_valid=0 is ignored.
- Simultaneous accept + rx_read in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
- Overrun: accept while rx_valid=1 and rx_read=0 -> rx_data overwritten with the new byte, rx_valid stays 1, overrun pulses 1 cycle.
- Latency: rx_valid rises 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 clocks (±1 for edge alignment) after the start-bit falling edge on rx_line.
- frame_error and overrun never assert together. All outputs are registered.

Decomposition:
- Shared package uart_pkg:
  - state encoding enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - constants DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- One sub-module, uart_sync: 2-flop synchronizer with reset value 1. uart_rx instantiates it on rx_line.

Test Plan (CLKS_PER_BIT=16):
- Frame 0xA5 at 16 clk/bit, rx_read held 0 -> rx_data=0xA5, rx_valid rises 155±1 clocks after the start edge, frame_error=0, overrun=0.
- rx_line low for 4 clocks, then high -> busy pulses briefly, FSM returns to IDLE, rx_valid stays 0, no flags.
- Frame 0x3C with stop bit driven 0, line then held low 40 clocks, then high -> frame_error one pulse, rx_valid=0, busy held until the line goes high. A following frame 0x5A is then received correctly.
- Frames 0x11 then 0x22 back-to-back, no rx_read -> overrun pulses once at the second accept, rx_data=0x22, rx_valid=1.
- Frame 0x77 with rx_read pulsed exactly on the accept cycle of a previous 0x66 sequence -> rx_data=0x77, rx_valid=1, overrun=0.
- Assert reset low mid-DATA of frame 0xFF, release, then send 0x0F -> all outputs 0 during reset, partial byte discarded, rx_data=0x0F afterwards.
